// File: rtl/scr_pkg.sv
// scr_pkg: symbol constants, polynomial taps and per-byte context types
// shared by the PIPE TX scrambler.
package scr_pkg;

   localparam logic [7:0]  COM         = 8'hBC;
   localparam logic [7:0]  SKP         = 8'h1C;
   localparam logic [1:0]  SH_DATA     = 2'b10;
   localparam logic [1:0]  SH_OS       = 2'b01;
   localparam logic [7:0]  OS_EIEOS    = 8'h00;
   localparam logic [7:0]  OS_SKP      = 8'hAA;
   localparam logic [15:0] LFSR16_SEED = 16'hFFFF;

   // Galois feedback taps below the top term of each polynomial
   localparam logic [15:0] POLY16 = 16'h0038;
   localparam logic [22:0] POLY23 = 23'h210124;

   typedef enum logic [1:0] {
      OS_NONE,
      OS_EIE,
      OS_SKIP,
      OS_OTHER
   } os_type_e;

   typedef struct packed {
      logic [22:0] lfsr;
      logic [3:0]  cnt;
      os_type_e    os;
      logic        act;
      logic [1:0]  sh;
   } ctx_t;

   typedef struct packed {
      ctx_t       ctx;
      logic [7:0] data;
   } step_t;

   function automatic os_type_e os_decode(input logic [7:0] b);
      os_type_e t;
      unique case (1'b1)
         (b == OS_EIEOS): t = OS_EIE;
         (b == OS_SKP):   t = OS_SKIP;
         default:         t = OS_OTHER;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tx_scrambler_if.sv
// tx_scrambler_if: link-layer word in, scrambled PIPE word out.
// master drives the TX word, slave is the scrambler.
interface tx_scrambler_if;

   logic        dataValid;
   logic        startBlock;
   logic [1:0]  syncHeader;
   logic [31:0] txData;
   logic [3:0]  txDataK;

   logic        scrDataValid;
   logic [1:0]  scrSyncHeader;
   logic        scrStartBlock;
   logic [31:0] scrData;
   logic [3:0]  scrDataK;

   modport master (
      output dataValid, startBlock, syncHeader, txData, txDataK,
      input  scrDataValid, scrSyncHeader, scrStartBlock,
      input  scrData, scrDataK
   );

   modport slave (
      input  dataValid, startBlock, syncHeader, txData, txDataK,
      output scrDataValid, scrSyncHeader, scrStartBlock,
      output scrData, scrDataK
   );

endinterface

// File: rtl/scr_lfsr_byte.sv
// scr_lfsr_byte: eight serial LFSR shifts for one byte lane; the
// scrambling bit for each shift is the LFSR MSB before that shift.
module scr_lfsr_byte
   import scr_pkg::*;
(
   input  logic [22:0] state,
   input  logic        gen3Mode,
   output logic [22:0] nxt,
   output logic [7:0]  sbyte
);

   logic [22:0] s;

   always_comb begin
      s     = state;
      sbyte = '0;
      for (int i = 0; i < 8; i++) begin
         if (gen3Mode) begin
            sbyte[i] = s[22];
            s = {s[21:0], s[22]}
              ^ (s[22] ? POLY23 : 23'd0);
         end else begin
            sbyte[i] = s[15];
            s = {7'd0, s[14:0], s[15]}
              ^ {7'd0, (s[15] ? POLY16 : 16'd0)};
         end
      end
      nxt = s;
   end

endmodule

// File: rtl/tx_scrambler.sv
// tx_scrambler: single-lane PIPE TX scrambler, Gen1/2 8b/10b and
// Gen3+ 128b/130b rules, four byte lanes chained per word.
module tx_scrambler
   import scr_pkg::*;
(
   input logic        clk,
   input logic        reset,
   input logic        turnOff,
   input logic        gen3Mode,
   input logic [5:0]  PIPEWIDTH,
   input logic [23:0] seedValue,
   tx_scrambler_if.slave bus
);

   function automatic step_t byte_step(
      input ctx_t        c_in,
      input logic [22:0] st_adv,
      input logic [7:0]  sb,
      input logic [7:0]  d,
      input logic        k,
      input logic        on,
      input logic        sob,
      input logic [1:0]  sh_in,
      input logic        g3,
      input logic [22:0] sd
   );
      step_t r;
      logic  scr;
      logic  adv;
      r.ctx  = c_in;
      r.data = d;
      scr    = 1'b0;
      adv    = 1'b0;
      if (on && !g3) begin
         if (k && d == COM)
            r.ctx.lfsr = {7'd0, LFSR16_SEED};
         else if (!(k && d == SKP)) begin
            adv = 1'b1;
            scr = ~k;
         end
      end else if (on) begin
         if (sob) begin
            r.ctx.cnt = 4'd0;
            r.ctx.sh  = sh_in;
            r.ctx.act = 1'b1;
            r.ctx.os  = OS_NONE;
         end
         if (r.ctx.act && r.ctx.sh == SH_DATA) begin
            adv = 1'b1;
            scr = 1'b1;
         end else if (r.ctx.act) begin
            // SKP OS may run past 16 bytes, so its type survives the wrap
            if (r.ctx.cnt == 4'd0 && r.ctx.os != OS_SKIP)
               r.ctx.os = os_decode(d);
            adv = (r.ctx.os == OS_EIE) || (r.ctx.os == OS_OTHER);
            scr = (r.ctx.os == OS_OTHER) && (r.ctx.cnt != 4'd0);
         end
      end
      if (adv)
         r.ctx.lfsr = st_adv;
      if (on && g3 && r.ctx.act) begin
         if (r.ctx.sh != SH_DATA && r.ctx.os == OS_EIE
             && r.ctx.cnt == 4'd15)
            r.ctx.lfsr = sd;
         r.ctx.cnt = r.ctx.cnt + 4'd1;
      end
      if (scr)
         r.data = d ^ sb;
      return r;
   endfunction

   logic [15:0] lfsr16;
   logic [22:0] lfsr23;
   logic [3:0]  blk_cnt;
   os_type_e    os_q;
   logic        act_q;
   logic [1:0]  sh_q;
   logic        load_pending;
   logic        gen3_q;

   logic        toggle;
   logic        load;
   logic        run;
   logic [22:0] seed;
   logic [15:0] l16_start;
   logic [22:0] l23_start;
   logic [3:0]  en;
   logic        unused_seed_msb;

   ctx_t        c0, c1, c2, c3, c4;
   step_t       r0, r1, r2, r3;
   logic [22:0] n0, n1, n2, n3;
   logic [7:0]  k0, k1, k2, k3;

   assign seed            = seedValue[22:0];
   assign unused_seed_msb = seedValue[23];
   assign toggle          = gen3Mode ^ gen3_q;
   assign load            = load_pending | toggle;
   assign run             = bus.dataValid & ~turnOff;
   assign l16_start       = load ? LFSR16_SEED : lfsr16;
   assign l23_start       = load ? seed : lfsr23;

   always_comb begin
      en = 4'b1111;
      unique case (PIPEWIDTH)
         6'd8:    en = 4'b0001;
         6'd16:   en = 4'b0011;
         default: en = 4'b1111;
      endcase
   end

   assign c0 = '{
      lfsr: gen3Mode ? l23_start : {7'd0, l16_start},
      cnt:  blk_cnt,
      os:   os_q,
      act:  act_q & ~toggle,
      sh:   sh_q
   };

   scr_lfsr_byte u_b0 (
      .state(c0.lfsr), .gen3Mode(gen3Mode), .nxt(n0), .sbyte(k0)
   );
   scr_lfsr_byte u_b1 (
      .state(c1.lfsr), .gen3Mode(gen3Mode), .nxt(n1), .sbyte(k1)
   );
   scr_lfsr_byte u_b2 (
      .state(c2.lfsr), .gen3Mode(gen3Mode), .nxt(n2), .sbyte(k2)
   );
   scr_lfsr_byte u_b3 (
      .state(c3.lfsr), .gen3Mode(gen3Mode), .nxt(n3), .sbyte(k3)
   );

   assign r0 = byte_step(c0, n0, k0, bus.txData[7:0],
                         bus.txDataK[0], en[0],
                         bus.startBlock & gen3Mode,
                         bus.syncHeader, gen3Mode, seed);
   assign c1 = r0.ctx;
   assign r1 = byte_step(c1, n1, k1, bus.txData[15:8],
                         bus.txDataK[1], en[1], 1'b0,
                         bus.syncHeader, gen3Mode, seed);
   assign c2 = r1.ctx;
   assign r2 = byte_step(c2, n2, k2, bus.txData[23:16],
                         bus.txDataK[2], en[2], 1'b0,
                         bus.syncHeader, gen3Mode, seed);
   assign c3 = r2.ctx;
   assign r3 = byte_step(c3, n3, k3, bus.txData[31:24],
                         bus.txDataK[3], en[3], 1'b0,
                         bus.syncHeader, gen3Mode, seed);
   assign c4 = r3.ctx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr16            <= LFSR16_SEED;
         lfsr23            <= '0;
         blk_cnt           <= '0;
         os_q              <= OS_NONE;
         act_q             <= 1'b0;
         sh_q              <= '0;
         load_pending      <= 1'b1;
         gen3_q            <= 1'b0;
         bus.scrDataValid  <= 1'b0;
         bus.scrSyncHeader <= '0;
         bus.scrStartBlock <= 1'b0;
         bus.scrData       <= '0;
         bus.scrDataK      <= '0;
      end else begin
         gen3_q       <= gen3Mode;
         load_pending <= 1'b0;
         if (run) begin
            if (gen3Mode) begin
               lfsr23 <= c4.lfsr;
               lfsr16 <= l16_start;
            end else begin
               lfsr16 <= c4.lfsr[15:0];
               lfsr23 <= l23_start;
            end
            blk_cnt <= c4.cnt;
            os_q    <= c4.os;
            act_q   <= c4.act;
            sh_q    <= c4.sh;
         end else begin
            lfsr16 <= l16_start;
            lfsr23 <= l23_start;
            act_q  <= act_q & ~toggle;
         end
         bus.scrDataValid  <= bus.dataValid;
         bus.scrSyncHeader <= bus.syncHeader;
         bus.scrStartBlock <= bus.startBlock;
         bus.scrDataK      <= bus.txDataK;
         bus.scrData       <= run
            ? {r3.data, r2.data, r1.data, r0.data}
            : bus.txData;
      end
   end

endmodule

// File: tb/tb_tx_scrambler.sv
// tb_tx_scrambler: directed and randomized words checked against a
// polynomial-arithmetic reference model and known scrambler values.
module tb_tx_scrambler;

   logic        clk = 1'b0;
   logic        reset;
   logic        turnOff;
   logic        gen3Mode;
   logic [5:0]  PIPEWIDTH;
   logic [23:0] seedValue;

   tx_scrambler_if bus ();

   tx_scrambler dut (
      .clk(clk), .reset(reset), .turnOff(turnOff),
      .gen3Mode(gen3Mode), .PIPEWIDTH(PIPEWIDTH),
      .seedValue(seedValue), .bus(bus)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] P16 = 32'h0001_0039;
   localparam logic [31:0] P23 = 32'h00A1_0125;
   localparam int M_NONE = 0;
   localparam int M_EIE  = 1;
   localparam int M_SKP  = 2;
   localparam int M_OTH  = 3;

   int          tests = 0;
   int          fails = 0;
   string       phase = "init";

   logic [31:0] m16, m23;
   int          mcnt, mos;
   bit          mact, mload, mg3q;
   logic [1:0]  msh;

   logic [31:0] last_out;
   logic [7:0]  tbl [16];
   logic [31:0] blk_a [4];
   logic [31:0] blk_a2 [4];
   logic [31:0] rd;
   logic [3:0]  rk;
   logic [5:0]  rw;
   logic [1:0]  rsh;
   bit          sob;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s/%s observed=%h expected=%h",
                phase, tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m16 = 32'hFFFF; m23 = 0; mcnt = 0; mos = M_NONE;
      mact = 0; msh = 0; mload = 1; mg3q = 0;
   endtask

   // multiply the state by x modulo the polynomial, MSB first out
   function automatic logic [7:0] mk_byte(input bit g3);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         if (g3) begin
            b[i] = m23[22];
            m23 = m23 << 1;
            if (m23[23]) m23 = m23 ^ P23;
         end else begin
            b[i] = m16[15];
            m16 = m16 << 1;
            if (m16[16]) m16 = m16 ^ P16;
         end
      end
      return b;
   endfunction

   function automatic logic [31:0] model(
      input logic [31:0] d, input logic [3:0] k, input bit g3,
      input bit v, input bit off, input bit sb, input logic [1:0] sh,
      input logic [5:0] w, input logic [23:0] seed);
      logic [31:0] o;
      logic [7:0]  b, s;
      int          n;
      if (mload || g3 != mg3q) begin
         m16 = 32'hFFFF;
         m23 = {9'd0, seed[22:0]};
         if (g3 != mg3q) mact = 0;
      end
      mload = 0;
      mg3q  = g3;
      o = d;
      if (!v || off) return o;
      n = (w == 6'd8) ? 1 : (w == 6'd16) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
         b = d[8*i +: 8];
         if (!g3) begin
            if (k[i] && b == 8'hBC) m16 = 32'hFFFF;
            else if (!(k[i] && b == 8'h1C)) begin
               s = mk_byte(0);
               if (!k[i]) o[8*i +: 8] = b ^ s;
            end
         end else begin
            if (i == 0 && sb) begin
               mcnt = 0; msh = sh; mact = 1; mos = M_NONE;
            end
            if (mact) begin
               if (msh == 2'b10) o[8*i +: 8] = b ^ mk_byte(1);
               else begin
                  if (mcnt == 0 && mos != M_SKP)
                     mos = (b == 8'h00) ? M_EIE :
                           (b == 8'hAA) ? M_SKP : M_OTH;
                  if (mos == M_EIE) begin
                     s = mk_byte(1);
                     if (mcnt == 15) m23 = {9'd0, seed[22:0]};
                  end else if (mos == M_OTH) begin
                     s = mk_byte(1);
                     if (mcnt != 0) o[8*i +: 8] = b ^ s;
                  end
               end
               mcnt = (mcnt + 1) % 16;
            end
         end
      end
      return o;
   endfunction

   task automatic drive(input bit v, input bit off, input bit sb,
                        input logic [1:0] sh, input logic [5:0] w,
                        input logic [31:0] d, input logic [3:0] k);
      logic [31:0] e;
      bus.dataValid  = v;
      turnOff        = off;
      bus.startBlock = sb;
      bus.syncHeader = sh;
      PIPEWIDTH      = w;
      bus.txData     = d;
      bus.txDataK    = k;
      e = model(d, k, gen3Mode, v, off, sb, sh, w, seedValue);
      @(posedge clk);
      #1;
      last_out = bus.scrData;
      check("valid", {31'd0, bus.scrDataValid}, {31'd0, v});
      check("kflag", {28'd0, bus.scrDataK}, {28'd0, k});
      check("hdr", {29'd0, bus.scrStartBlock, bus.scrSyncHeader},
            {29'd0, sb, sh});
      if (v || off) check("data", bus.scrData, e);
   endtask

   task automatic check_zero();
      check("rst_data", bus.scrData, 32'd0);
      check("rst_valid", {31'd0, bus.scrDataValid}, 32'd0);
      check("rst_k", {28'd0, bus.scrDataK}, 32'd0);
      check("rst_hdr", {29'd0, bus.scrStartBlock,
                        bus.scrSyncHeader}, 32'd0);
   endtask

   initial begin
      tbl = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
              8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};
      reset = 1'b0; turnOff = 1'b0; gen3Mode = 1'b0;
      PIPEWIDTH = 6'd8; seedValue = 24'h1DBFBC;
      bus.dataValid = 1'b0; bus.startBlock = 1'b0;
      bus.syncHeader = 2'b00; bus.txData = '0; bus.txDataK = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      phase = "reset";
      check_zero();
      reset = 1'b1;

      phase = "g1_table";
      drive(1, 0, 0, 2'b00, 6'd8, 32'h0000_00BC, 4'h1);
      check("com", last_out, 32'h0000_00BC);
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
         check("seq", last_out, {24'd0, tbl[i]});
      end

      phase = "g1_w32";
      drive(1, 0, 0, 2'b00, 6'd32, 32'h0000_1CBC, 4'b0011);
      check("word", last_out, 32'h17FF_1CBC);

      phase = "g1_skp";
      drive(1, 0, 0, 2'b00, 6'd8, 32'h0000_00BC, 4'h1);
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      check("b0", last_out, 32'h0000_00FF);
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      check("b1", last_out, 32'h0000_0017);
      drive(1, 0, 0, 2'b00, 6'd8, 32'h0000_001C, 4'h1);
      check("skp", last_out, 32'h0000_001C);
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      check("b2", last_out, 32'h0000_00C0);
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      check("b3", last_out, 32'h0000_0014);

      phase = "g1_hold";
      drive(1, 0, 0, 2'b00, 6'd8, 32'h0000_00BC, 4'h1);
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      check("b1", last_out, 32'h0000_0017);
      for (int i = 0; i < 3; i++)
         drive(0, 0, 0, 2'b00, 6'd8, $urandom, 4'h0);
      for (int i = 0; i < 2; i++) begin
         rd = $urandom;
         drive(1, 1, 0, 2'b00, 6'd8, rd, 4'h0);
         check("bypass", last_out, rd);
      end
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      check("b2", last_out, 32'h0000_00C0);
      drive(1, 0, 0, 2'b00, 6'd8, 32'd0, 4'h0);
      check("b3", last_out, 32'h0000_0014);

      phase = "g1_rand";
      for (int i = 0; i < 24; i++) begin
         rd = $urandom;
         rk = '0;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) begin
               rk[b] = 1'b1;
               case ($urandom_range(0, 2))
                  0: rd[8*b +: 8] = 8'hBC;
                  1: rd[8*b +: 8] = 8'h1C;
                  default: ;
               endcase
            end
         case ($urandom_range(0, 3))
            0: rw = 6'd8;
            1: rw = 6'd16;
            2: rw = 6'd32;
            default: rw = 6'd20;
         endcase
         drive(1, 0, 0, 2'b00, rw, rd, rk);
      end

      phase = "g3_blocks";
      gen3Mode = 1'b1;
      drive(0, 0, 0, 2'b00, 6'd32, 32'd0, 4'h0);
      drive(0, 0, 0, 2'b00, 6'd32, 32'd0, 4'h0);
      for (int w = 0; w < 4; w++) begin
         drive(1, 0, w == 0, 2'b10, 6'd32, 32'd0, 4'h0);
         blk_a[w] = last_out;
      end
      for (int w = 0; w < 4; w++) begin
         drive(1, 0, w == 0, 2'b10, 6'd32, 32'd0, 4'h0);
         blk_a2[w] = last_out;
      end
      for (int w = 0; w < 4; w++) begin
         drive(1, 0, w == 0, 2'b01, 6'd32, 32'd0, 4'h0);
         check("eieos", last_out, 32'd0);
      end
      for (int w = 0; w < 4; w++) begin
         drive(1, 0, w == 0, 2'b10, 6'd32, 32'd0, 4'h0);
         check("reseed", last_out, blk_a[w]);
      end
      for (int w = 0; w < 3; w++) begin
         drive(1, 0, w == 0, 2'b01, 6'd32, 32'hAAAA_AAAA, 4'h0);
         check("skpos", last_out, 32'hAAAA_AAAA);
      end
      for (int w = 0; w < 4; w++) begin
         drive(1, 0, w == 0, 2'b10, 6'd32, 32'd0, 4'h0);
         check("after_skp", last_out, blk_a2[w]);
      end

      phase = "g3_ts1";
      rd = $urandom;
      drive(1, 0, 1, 2'b01, 6'd32, {rd[31:8], 8'h1E}, 4'h0);
      check("ts_b0", {24'd0, last_out[7:0]}, 32'h0000_001E);
      for (int w = 1; w < 4; w++)
         drive(1, 0, 0, 2'b01, 6'd32, $urandom, 4'h0);

      phase = "g3_rand";
      for (int i = 0; i < 48; i++) begin
         rd  = $urandom;
         sob = (i % 5 == 0) || ($urandom_range(0, 6) == 0);
         rsh = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
         if (sob)
            case ($urandom_range(0, 3))
               0: rd[7:0] = 8'h00;
               1: rd[7:0] = 8'hAA;
               2: rd[7:0] = 8'h2D;
               default: ;
            endcase
         rw = ($urandom_range(0, 3) == 0) ? 6'd16 : 6'd32;
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
               sob, rsh, rw, rd, 4'h0);
      end

      phase = "g3_midreset";
      drive(1, 0, 1, 2'b10, 6'd32, $urandom, 4'h0);
      drive(1, 0, 0, 2'b10, 6'd32, $urandom, 4'h0);
      reset = 1'b0;
      bus.dataValid = 1'b0;
      @(posedge clk);
      #1;
      check_zero();
      model_reset();
      reset = 1'b1;
      rd = $urandom;
      drive(1, 0, 0, 2'b10, 6'd32, rd, 4'h0);
      check("no_block", last_out, rd);
      for (int w = 0; w < 4; w++) begin
         drive(1, 0, w == 0, 2'b10, 6'd32, 32'd0, 4'h0);
         check("fresh", last_out, blk_a[w]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tx_scrambler.md
# tx_scrambler

- Transmit-side PIPE scrambler for one lane.
- Sits between the link-layer TX datapath and the PIPE TX interface.
- Applies the Gen1/2 16-bit LFSR (8b/10b symbols) or the Gen3+ 23-bit LFSR (128b/130b blocks), with the PCIe symbol/ordered-set exceptions.
- Output is registered, so downstream logic sees a scrambled word exactly one cycle after the input word.

## Interface
Parameters:
- none; widths are fixed at a 32-bit PIPE datapath.

Ports:
- clk  in  1  PIPE clock.
- reset  in  1  asynchronous, active-low.
- turnOff  in  1  1 = bypass: data passes unscrambled and the LFSR holds.
- gen3Mode  in  1  0 = Gen1/2 rules, 1 = Gen3+ rules. Static while dataValid is high.
- dataValid  in  1  input word valid.
- startBlock  in  1  Gen3: first word of a 130-bit block. Ignored in Gen1/2.
- syncHeader  in  2  Gen3 block type, sampled with startBlock: 2'b10 data, 2'b01 ordered set.
- PIPEWIDTH  in  6  active bytes: 8→1, 16→2, 32→4. Any other value is treated as 32.
- seedValue  in  24  Gen3 per-lane seed; bits [22:0] are used.
- txData  in  32  byte 0 = bits [7:0], first in time.
- txDataK  in  4  per-byte K flag (Gen1/2).
- scrDataValid  out  1  registered dataValid.
- scrSyncHeader  out  2  registered syncHeader.
- scrStartBlock  out  1  registered startBlock.
- scrData  out  32  scrambled data.
- scrDataK  out  4  registered txDataK.

## Operation
- Bytes are processed in order 0..N-1, with N set by PIPEWIDTH. Inactive upper bytes pass through unchanged.
- Each byte that advances the LFSR consumes 8 serial shifts. The LFSR state is chained across bytes within one word.
- dataValid=0: the LFSR and the block counter hold.

Gen1/2 rules, per byte (polynomial x^16+x^5+x^4+x^3+1):
- K=1, 0xBC (COM): sent unscrambled; the LFSR is reset to 16'hFFFF for the following byte.
- K=1, 0x1C (SKP): sent unscrambled; no advance.
- Other K byte: sent unscrambled; LFSR advances.
- Data byte: XORed with the scrambling byte; LFSR advances.

Gen3+ rules (polynomial x^23+x^21+x^16+x^8+x^5+x^2+1):
- blkCnt (0..15) counts block bytes. startBlock forces blkCnt=0 at byte 0 and latches syncHeader.
- Data block: all 16 bytes scrambled; LFSR advances on every byte.
- Ordered-set block: block byte 0 selects the type, which is latched for the rest of the block.
  - 0x00 EIEOS: no scrambling. LFSR advances; after block byte 15 the LFSR reloads seedValue.
  - 0xAA SKP OS: no scrambling, no advance, for the whole block. A SKP OS may be 8–24 bytes; the block ends at the next startBlock.
  - Any other type (TS1 0x1E, TS2 0x2D, ...): byte 0 unscrambled, bytes 1–15 scrambled; LFSR advances on all 16 bytes.
- blkCnt wraps 15→0 even without startBlock. A startBlock arriving mid-block aborts the block and restarts the count; the LFSR is not reset.

Reset and bypass:
- LFSR16 resets to 16'hFFFF.
- LFSR23 is loaded from seedValue in the first cycle after reset deassertion, via a loadPending flag set by reset.
- A gen3Mode toggle reloads both LFSRs the next cycle.
- turnOff=1: scrData = txData; LFSRs and blkCnt hold.

## Timing
- Latency: 1 cycle for all outputs. Throughput: 1 word per cycle, no backpressure.
- Every output resets to 0.
- A COM in byte k resets the LFSR for byte k+1 in the same word.
- Reset asserted mid-block: block state is lost. After release, the LFSR reloads and blkCnt waits for startBlock.

## Structure
- Package scr_pkg holds:
  - COM 8'hBC, SKP 8'h1C, SH_DATA 2'b10, SH_OS 2'b01, OS_EIEOS 8'h00, OS_SKP 8'hAA;
  - LFSR16_SEED 16'hFFFF;
  - typedef os_type_e {OS_NONE, OS_EIE, OS_SKIP, OS_OTHER}.
- Sub-module scr_lfsr_byte: combinational 8-shift advance for both polynomials.
  - Inputs: state, gen3Mode.
  - Outputs: next state, scrambling byte.
  - Four instances are chained for the 4 byte lanes.

## Test plan
- Gen1, width 8: COM(K) then 16 data bytes of 0x00 → scrData = BC, FF,17,C0,14,B2,E7,02,82,72,6E,28,A6,BE,6D,BF,8D.
- Gen1, width 32, word {00,00,1C(K),BC(K)} → bytes 0–1 pass unscrambled, byte 2 = 0xFF, byte 3 = 0x17.
- Gen1: SKP(K) inserted between data bytes → the scrambling sequence continues unbroken across the SKP; the SKP byte is output unchanged.
- Gen3, width 32: seed 0x1DBFBC, data block of zeros, then EIEOS (16 × 0x00, header 01), then the same data block → both data blocks produce identical scrambled output; EIEOS output is all zeros.
- Gen3: SKP OS block of 0xAA between two data blocks → the second data block continues the sequence as if the SKP OS were absent.
- dataValid=0 for 3 cycles and turnOff=1 for 2 cycles mid-stream → LFSR holds; during bypass scrData equals txData; the sequence resumes with no skipped bytes.
